present_core_arbiter: RTL

- Shares one PRESENT-80 `encrypt` core between two requesters using round-robin arbitration.
- Latches the granted requester's key and plaintext and drives the core's key, plaintext and enable inputs.
- Holds enable high for a fixed CORE_LATENCY window, then captures the ciphertext and returns it with a valid/ack handshake.
- Sits between the requester logic and the unmodified `encrypt` instance.

---
 rtl/present_core_arbiter_if.sv | 35 +++
 rtl/present_core_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/present_core_arbiter_if.sv
// Signal bundle linking two requesters, the arbiter and one shared PRESENT-80 encrypt core.
// Requesters hold reqN (with keyN/ptN valid) until acceptN pulses; doneN holds ct_out until ackN is sampled high.
interface present_core_arbiter_if;
    logic        req0;
    logic        req1;
    logic [79:0] key0;
    logic [79:0] key1;
    logic [63:0] pt0;
    logic [63:0] pt1;
    logic        accept0;
    logic        accept1;
    logic        done0;
    logic        done1;
    logic        ack0;
    logic        ack1;
    logic [63:0] ct_out;
    logic        busy;
    logic [79:0] core_key;
    logic [63:0] core_plaintext;
    logic        core_enable;
    logic [63:0] core_ciphertext;
    logic [1:0]  dbg_state;

    modport slave (
        input  req0, req1, key0, key1, pt0, pt1, ack0, ack1, core_ciphertext,
        output accept0, accept1, done0, done1, ct_out, busy,
               core_key, core_plaintext, core_enable, dbg_state
    );

    modport master (
        output req0, req1, key0, key1, pt0, pt1, ack0, ack1, core_ciphertext,
        input  accept0, accept1, done0, done1, ct_out, busy,
               core_key, core_plaintext, core_enable, dbg_state
    );
endinterface

// File: rtl/present_core_arbiter.sv
// Round-robin arbiter sharing one PRESENT-80 encrypt core between two requesters.
// Operands are latched on grant, enable is held for CORE_LATENCY cycles, then the result is captured.
module present_core_arbiter #(
    parameter int CORE_LATENCY = 32,
    parameter int CNT_W        = 6
) (
    input  logic                   clock,
    input  logic                   reset_n,
    present_core_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_grant;
    logic [79:0]        r_core_key;
    logic [63:0]        r_core_plaintext;
    logic               r_core_enable;
    logic [63:0]        r_ct_out;
    logic               r_accept0;
    logic               r_accept1;
    logic               r_done0;
    logic               r_done1;
    logic               r_busy;

    logic               w_any_req;
    logic               w_grant_sel;
    logic               w_ack_g;

    assign w_any_req   = bus.req0 | bus.req1;
    // With both requesting, the one that did not win last time gets the core.
    assign w_grant_sel = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;
    assign w_ack_g     = r_grant ? bus.ack1 : bus.ack0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_last_grant     <= 1'b1;
            r_grant          <= 1'b0;
            r_core_key       <= '0;
            r_core_plaintext <= '0;
            r_core_enable    <= 1'b0;
            r_ct_out         <= '0;
            r_accept0        <= 1'b0;
            r_accept1        <= 1'b0;
            r_done0          <= 1'b0;
            r_done1          <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_accept0 <= 1'b0;
            r_accept1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant          <= w_grant_sel;
                        r_last_grant     <= w_grant_sel;
                        r_core_key       <= w_grant_sel ? bus.key1 : bus.key0;
                        r_core_plaintext <= w_grant_sel ? bus.pt1 : bus.pt0;
                        r_core_enable    <= 1'b1;
                        r_cnt            <= CNT_W'(1);
                        r_accept0        <= ~w_grant_sel;
                        r_accept1        <= w_grant_sel;
                        r_busy           <= 1'b1;
                        r_state          <= RUN;
                    end
                end
                RUN: begin
                    if (r_cnt == CNT_W'(CORE_LATENCY)) begin
                        r_ct_out      <= bus.core_ciphertext;
                        r_core_enable <= 1'b0;
                        r_done0       <= ~r_grant;
                        r_done1       <= r_grant;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (w_ack_g) begin
                        r_done0 <= 1'b0;
                        r_done1 <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_core_enable <= 1'b0;
                    r_done0       <= 1'b0;
                    r_done1       <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.accept0        = r_accept0;
    assign bus.accept1        = r_accept1;
    assign bus.done0          = r_done0;
    assign bus.done1          = r_done1;
    assign bus.ct_out         = r_ct_out;
    assign bus.busy           = r_busy;
    assign bus.core_key       = r_core_key;
    assign bus.core_plaintext = r_core_plaintext;
    assign bus.core_enable    = r_core_enable;
    assign bus.dbg_state      = r_state;
endmodule
